// File: rtl/pool_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pool_avg_pkg
// Brief    : Shared types and constants for the GAP pooling scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package pool_avg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_DIVIDE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_READ   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SZ_28      = 2'b00,
        SZ_14      = 2'b01,
        SZ_7       = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    localparam int unsigned NPIX_28 = 784;
    localparam int unsigned NPIX_14 = 196;
    localparam int unsigned NPIX_7  = 49;

    localparam int unsigned DIV_28 = 5;
    localparam int unsigned DIV_14 = 20;
    localparam int unsigned DIV_7  = 84;

    localparam int unsigned DRAIN_CYCLES = 2;

    function automatic int unsigned npix_of(input logic [1:0] sz);
        int unsigned n;
        case (sz)
            SZ_28:   n = NPIX_28;
            SZ_14:   n = NPIX_14;
            default: n = NPIX_7;
        endcase
        return n;
    endfunction

    function automatic logic [18:0] div_of(input logic [1:0] sz);
        logic [18:0] d;
        case (sz)
            SZ_28:   d = 19'(DIV_28);
            SZ_14:   d = 19'(DIV_14);
            default: d = 19'(DIV_7);
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// Module   : wrap_counter
// Brief    : Stepping counter that returns to zero when count+STEP hits limit.
// Revision : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int WIDTH = 11,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    // One extra bit so that count+STEP == limit works when limit is 2**(WIDTH-1) etc.
    localparam logic [WIDTH:0] c_step = STEP[WIDTH:0];

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_next;

    assign w_next = {1'b0, r_count} + c_step;
    assign wrap   = en && (w_next == {1'b0, limit});
    assign count  = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : w_next[WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/gap_pool_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gap_pool_scheduler
// Brief    : Sequences accumulate, divide and readout sweeps for global pooling.
// Revision : 1.0 - initial release
// ============================================================================
module gap_pool_scheduler
    import pool_avg_pkg::*;
#(
    parameter int CH_MAX = 1024,
    parameter int IDX_W  = 11,
    parameter int CNT_W  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       size,
    input  logic [IDX_W-1:0] ofm_c,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pool_valid,
    output logic [IDX_W-1:0] pixel_index,
    output logic             init_phase,
    output logic [18:0]      div_param,
    output logic             div_valid,
    output logic [IDX_W-1:0] div_index,
    output logic             rd_valid,
    output logic [IDX_W-1:0] rd_index,
    input  logic             rd_ready,
    output logic             busy,
    output logic             done,
    output logic             err_cfg
);

    localparam logic [IDX_W:0] c_ch_max     = (IDX_W+1)'(CH_MAX);
    localparam logic [1:0]     c_drain_last = 2'(DRAIN_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [1:0]       r_size;
    logic [IDX_W-1:0] r_ofm_c;
    logic [18:0]      r_div_param;
    logic             r_err_cfg;
    logic             r_div_valid;
    logic             r_rd_valid;
    logic             r_done;
    logic             r_busy;
    logic [1:0]       r_drain_cnt;

    logic             w_accum;
    logic             w_accept_start;
    logic             w_cfg_legal;
    logic             w_ch_wrap;
    logic             w_pix_wrap;
    logic             w_div_wrap;
    logic             w_rd_wrap;
    logic [CNT_W-1:0] w_npix;
    logic [CNT_W-1:0] w_pix_cnt;
    logic [IDX_W-1:0] w_ch_ptr;

    assign w_accum        = (r_state == ST_ACCUM);
    assign w_accept_start = (r_state == ST_IDLE) && start;
    assign w_cfg_legal    = (size != SZ_ILLEGAL) && (ofm_c[1:0] == 2'b00) &&
                            (ofm_c != '0) && ({1'b0, ofm_c} <= c_ch_max);
    assign w_npix         = CNT_W'(npix_of(r_size));

    assign in_ready    = w_accum;
    assign pool_valid  = in_valid && w_accum;
    assign pixel_index = w_ch_ptr;
    assign init_phase  = w_accum && (w_pix_cnt == '0);
    assign div_param   = r_div_param;
    assign div_valid   = r_div_valid;
    assign rd_valid    = r_rd_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_cfg     = r_err_cfg;

    wrap_counter #(.WIDTH(IDX_W), .STEP(4)) u_ch_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pool_valid),
        .clr     (w_accept_start),
        .limit   (r_ofm_c),
        .count   (w_ch_ptr),
        .wrap    (w_ch_wrap)
    );

    // Pixel counter advances once per full channel sweep.
    wrap_counter #(.WIDTH(CNT_W), .STEP(1)) u_pix_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_ch_wrap),
        .clr     (w_accept_start),
        .limit   (w_npix),
        .count   (w_pix_cnt),
        .wrap    (w_pix_wrap)
    );

    wrap_counter #(.WIDTH(IDX_W), .STEP(1)) u_div_idx (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (r_div_valid),
        .clr     (w_accept_start),
        .limit   (r_ofm_c),
        .count   (div_index),
        .wrap    (w_div_wrap)
    );

    wrap_counter #(.WIDTH(IDX_W), .STEP(1)) u_rd_idx (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (r_rd_valid && rd_ready),
        .clr     (w_accept_start),
        .limit   (r_ofm_c),
        .count   (rd_index),
        .wrap    (w_rd_wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept_start && w_cfg_legal) w_state_nxt = ST_ACCUM;
            ST_ACCUM:  if (w_pix_wrap) w_state_nxt = ST_DIVIDE;
            ST_DIVIDE: if (w_div_wrap) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (r_drain_cnt == c_drain_last) w_state_nxt = ST_READ;
            ST_READ:   if (w_rd_wrap) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_size      <= 2'b00;
            r_ofm_c     <= '0;
            r_div_param <= '0;
            r_err_cfg   <= 1'b0;
            r_div_valid <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_valid <= (w_state_nxt == ST_DIVIDE);
            r_rd_valid  <= (w_state_nxt == ST_READ);
            r_done      <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
            if (w_accept_start) begin
                r_size    <= size;
                r_ofm_c   <= ofm_c;
                r_err_cfg <= !w_cfg_legal;
                if (w_cfg_legal) begin
                    r_div_param <= div_of(size);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gap_pool_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gap_pool_scheduler
// Brief    : Directed self-checking bench for gap_pool_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gap_pool_scheduler;

    localparam int IDX_W = 11;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       size = 2'b00;
    logic [IDX_W-1:0] ofm_c = '0;
    logic             in_valid = 1'b0;
    logic             rd_ready = 1'b0;
    logic             in_ready, pool_valid, init_phase, div_valid, rd_valid;
    logic             busy, done, err_cfg;
    logic [IDX_W-1:0] pixel_index, div_index, rd_index;
    logic [18:0]      div_param;

    int checks   = 0;
    int failures = 0;

    int beats, pix_err, init_cnt, div_cnt, div_err, first_div, drain_cnt;
    int rd_cnt, rd_err, hold_cnt, done_cnt, done_cyc, last_beat;

    always #5 clk = ~clk;

    gap_pool_scheduler #(.CH_MAX(1024), .IDX_W(IDX_W), .CNT_W(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .size        (size),
        .ofm_c       (ofm_c),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pool_valid  (pool_valid),
        .pixel_index (pixel_index),
        .init_phase  (init_phase),
        .div_param   (div_param),
        .div_valid   (div_valid),
        .div_index   (div_index),
        .rd_valid    (rd_valid),
        .rd_index    (rd_index),
        .rd_ready    (rd_ready),
        .busy        (busy),
        .done        (done),
        .err_cfg     (err_cfg)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Runs one layer; gap toggles in_valid, stall_idx>=0 holds rd_ready low 3 cycles there.
    task automatic run_layer(input logic [1:0] sz, input int oc, input bit gap,
                             input int stall_idx, input bit poke, input int exp_param);
        int npix, nbeats, cyc, stall_left, exp_done;
        bit poked_div, poked_rd;
        npix   = (sz == 2'b00) ? 784 : (sz == 2'b01) ? 196 : 49;
        nbeats = npix * oc / 4;
        beats = 0; pix_err = 0; init_cnt = 0; div_cnt = 0; div_err = 0; first_div = -1;
        drain_cnt = 0; rd_cnt = 0; rd_err = 0; hold_cnt = 0; done_cnt = 0; done_cyc = -1;
        last_beat = -1; stall_left = 3; poked_div = 0; poked_rd = 0; cyc = 0;

        @(posedge clk); #1;
        start = 1'b1; size = sz; ofm_c = oc[IDX_W-1:0];
        in_valid = !gap; rd_ready = 1'b1;
        while (cyc < 20000 && done_cnt == 0) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0; size = 2'b11; ofm_c = '0;
            in_valid = gap ? cyc[0] : 1'b1;
            rd_ready = 1'b1;
            if (stall_idx >= 0 && rd_valid && int'(rd_index) == stall_idx && stall_left > 0) begin
                rd_ready = 1'b0;
                stall_left--;
            end
            if (poke && div_valid && !poked_div) begin start = 1'b1; poked_div = 1; end
            if (poke && rd_valid && !poked_rd) begin start = 1'b1; poked_rd = 1; end
            #1;
            if (cyc == 1) begin
                check("in_ready_cycle1", in_ready, 1);
                check("err_cfg_cleared", err_cfg, 0);
                check("div_param", div_param, exp_param);
            end
            if (pool_valid) begin
                if (int'(pixel_index) != (beats % (oc / 4)) * 4) pix_err++;
                if (int'(init_phase) != int'(beats < oc / 4)) pix_err++;
                init_cnt += int'(init_phase);
                beats++;
                last_beat = cyc;
            end
            if (div_valid) begin
                if (div_cnt == 0) first_div = cyc;
                if (int'(div_index) != div_cnt) div_err++;
                div_cnt++;
            end
            if (busy && !in_ready && !div_valid && !rd_valid && !done) drain_cnt++;
            if (rd_valid) begin
                if (int'(rd_index) != rd_cnt) rd_err++;
                if (int'(rd_index) == stall_idx) hold_cnt++;
                if (rd_ready) rd_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("idle_after_done", {busy, done}, 0);

        exp_done = (gap ? 2 * nbeats - 1 : nbeats) + oc + 2 + oc + ((stall_idx >= 0) ? 3 : 0) + 1;
        check("beats", beats, nbeats);
        check("pixel_seq_errors", pix_err, 0);
        check("init_beats", init_cnt, oc / 4);
        check("div_count", div_cnt, oc);
        check("div_index_errors", div_err, 0);
        check("div_latency", first_div, last_beat + 1);
        check("drain_cycles", drain_cnt, 2);
        check("rd_count", rd_cnt, oc);
        check("rd_index_errors", rd_err, 0);
        check("done_pulses", done_cnt, 1);
        check("done_cycle", done_cyc, exp_done);
        if (stall_idx >= 0) check("rd_hold_cycles", hold_cnt, 4);
    endtask

    task automatic illegal_start(input logic [1:0] sz, input int oc);
        @(posedge clk); #1;
        start = 1'b1; size = sz; ofm_c = oc[IDX_W-1:0]; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("err_cfg_set", err_cfg, 1);
        check("busy_after_illegal", busy, 0);
        check("in_ready_after_illegal", in_ready, 0);
        repeat (3) @(posedge clk);
        #2;
        check("busy_stays_low", busy, 0);
        check("err_cfg_sticky", err_cfg, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset_flags", {busy, in_ready, pool_valid, init_phase, div_valid, rd_valid, done, err_cfg}, 0);
        check("reset_div_param", div_param, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_layer(2'b10, 8, 1'b0, -1, 1'b0, 84);
        run_layer(2'b10, 8, 1'b1, 5, 1'b0, 84);

        illegal_start(2'b11, 8);
        illegal_start(2'b10, 6);
        run_layer(2'b01, 4, 1'b0, -1, 1'b0, 20);

        // Abort mid-layer once 40 beats (pix_cnt=20) have been accepted.
        @(posedge clk); #1;
        start = 1'b1; size = 2'b10; ofm_c = 11'd8; in_valid = 1'b1; rd_ready = 1'b1;
        repeat (41) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #1;
        check("pre_reset_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_flags", {busy, in_ready, pool_valid, init_phase, div_valid, rd_valid, done, err_cfg}, 0);
        check("async_reset_div_param", div_param, 0);
        check("async_reset_indices", {pixel_index, div_index, rd_index}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_layer(2'b10, 8, 1'b0, -1, 1'b0, 84);

        run_layer(2'b10, 8, 1'b0, -1, 1'b1, 84);
        run_layer(2'b00, 4, 1'b0, -1, 1'b0, 5);
        run_layer(2'b10, 1024, 1'b0, -1, 1'b0, 84);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
